// File: rtl/e300_rx_framer.sv
// RX sample framer: collects 32-bit I/Q samples into a one-packet buffer, then emits
// a 64-bit CHDR packet (header, optional VITA time, payload with tlast on the last word).
module e300_rx_framer #(
    parameter int BUF_AW = 9,
    parameter int SEQ_W  = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic [31:0]      sid,
    input  logic [15:0]      spp,
    input  logic             use_time,
    input  logic [63:0]      vita_time,
    input  logic [31:0]      i_tdata,
    input  logic             i_teob,
    input  logic             i_tvalid,
    output logic             i_tready,
    output logic [63:0]      o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             o_tready,
    output logic [SEQ_W-1:0] seqnum
);
    localparam int CNT_W   = BUF_AW + 2;
    localparam int MAX_SPP = 2 ** (BUF_AW + 1);

    // state | meaning: COLLECT fill buffer | HDR header word | TIME timestamp word | PAYLOAD drain buffer
    typedef enum logic [1:0] {COLLECT, HDR, TIME, PAYLOAD} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0]  count, count_inc, spp_lat, spp_live, spp_cur, nsamp;
    logic              time_lat, time_cur, has_time, eob_lat, rdy_en;
    logic              accept, first, close, pay_done;
    logic [31:0]       pend_hi, sid_lat;
    logic [63:0]       time_word, rd_data, wr_word, hdr_word;
    logic [BUF_AW-1:0] rd_ptr, rd_addr, last_addr;
    logic [15:0]       len_bytes;
    logic [63:0]       mem [2**BUF_AW];

    always_comb begin
        spp_live = CNT_W'(spp);
        if (spp == '0)
            spp_live = CNT_W'(1);
        else if (32'(spp) > MAX_SPP)
            spp_live = CNT_W'(MAX_SPP);
    end

    // Packet parameters are taken live on the first sample, from the latches afterwards.
    assign first     = (count == '0);
    assign spp_cur   = first ? spp_live : spp_lat;
    assign time_cur  = first ? use_time : time_lat;
    assign count_inc = count + CNT_W'(1);
    assign i_tready  = rdy_en && (state == COLLECT);
    assign accept    = i_tvalid && i_tready;
    assign close     = accept && (i_teob || (count_inc == spp_cur));
    assign pay_done  = (state == PAYLOAD) && o_tready && o_tlast;

    assign last_addr = BUF_AW'((nsamp - CNT_W'(1)) >> 1);
    assign len_bytes = 16'd8 + (has_time ? 16'd8 : 16'd0) + 16'({nsamp, 2'b00});
    assign hdr_word  = {2'b00, has_time, eob_lat, 12'(seqnum), len_bytes, sid_lat};
    assign wr_word   = count[0] ? {pend_hi, i_tdata} : {i_tdata, 32'h0};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        o_tvalid  = 1'b0;
        o_tlast   = 1'b0;
        o_tdata   = '0;
        rd_addr   = '0;
        case (state)
            COLLECT: begin
                if (close)
                    state_nxt = HDR;
            end
            HDR: begin
                o_tvalid = 1'b1;
                o_tdata  = hdr_word;
                if (o_tready)
                    state_nxt = has_time ? TIME : PAYLOAD;
            end
            TIME: begin
                o_tvalid = 1'b1;
                o_tdata  = time_word;
                if (o_tready)
                    state_nxt = PAYLOAD;
            end
            PAYLOAD: begin
                o_tvalid = 1'b1;
                o_tdata  = rd_data;
                o_tlast  = (rd_ptr == last_addr);
                rd_addr  = rd_ptr;
                // Advance the read address on a handshake so the next word is ready without a bubble.
                if (o_tready) begin
                    if (o_tlast) begin
                        state_nxt = COLLECT;
                        rd_addr   = '0;
                    end else begin
                        rd_addr = rd_ptr + BUF_AW'(1);
                    end
                end
            end
            default: state_nxt = COLLECT;
        endcase
        if (clear) begin
            state_nxt = COLLECT;
            rd_addr   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdy_en    <= 1'b0;
            count     <= '0;
            spp_lat   <= '0;
            time_lat  <= 1'b0;
            time_word <= '0;
            pend_hi   <= '0;
            nsamp     <= '0;
            has_time  <= 1'b0;
            eob_lat   <= 1'b0;
            sid_lat   <= '0;
            seqnum    <= '0;
            rd_ptr    <= '0;
        end else begin
            rdy_en <= 1'b1;
            rd_ptr <= rd_addr;
            if (clear) begin
                count  <= '0;
                seqnum <= '0;
            end else begin
                if (accept) begin
                    if (first) begin
                        spp_lat   <= spp_live;
                        time_lat  <= use_time;
                        time_word <= vita_time;
                    end
                    if (!count[0])
                        pend_hi <= i_tdata;
                    if (close) begin
                        count    <= '0;
                        nsamp    <= count_inc;
                        has_time <= time_cur;
                        eob_lat  <= i_teob;
                        sid_lat  <= sid;
                    end else begin
                        count <= count_inc;
                    end
                end
                if (pay_done)
                    seqnum <= seqnum + SEQ_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (count[0] || close))
            mem[count[BUF_AW:1]] <= wr_word;
        rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_e300_rx_framer.sv
// Self-checking bench for e300_rx_framer: fixed CHDR examples plus randomized packets
// compared against a packet-level model built from the sample queue.
module tb_e300_rx_framer;
    logic        clk = 1'b0, reset_n = 1'b0, clear = 1'b0;
    logic [31:0] sid = 32'h0001_0002;
    logic [15:0] spp = 16'd4;
    logic        use_time = 1'b0;
    logic [63:0] vita_time = '0;
    logic [31:0] i_tdata = '0;
    logic        i_teob = 1'b0, i_tvalid = 1'b0, o_tready = 1'b0;
    logic        i_tready, o_tlast, o_tvalid;
    logic [63:0] o_tdata;
    logic [11:0] seqnum;

    e300_rx_framer #(.BUF_AW(9), .SEQ_W(12)) dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .sid(sid), .spp(spp),
        .use_time(use_time), .vita_time(vita_time), .i_tdata(i_tdata), .i_teob(i_teob),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready), .seqnum(seqnum)
    );

    always #5 clk = ~clk;

    int          n_checks = 0, n_pass = 0;
    int          exp_seq = 0;
    logic [31:0] smp_q[$];
    logic [63:0] obs_q[$];
    logic [63:0] exp_q[$];
    int          last_idx, first_wait, stall_err, rdy_err;
    bit          timed_out, rdy_after;
    logic [63:0] t_first;

    function automatic int eff_spp(input int s);
        if (s == 0) return 1;
        if (s > 1024) return 1024;
        return s;
    endfunction

    function automatic logic [63:0] model_hdr(input bit ht, input bit eob, input int seq,
                                              input int n, input logic [31:0] s);
        logic [15:0] len;
        len = 16'(8 + 8 * int'(ht) + 4 * n);
        return {2'b00, ht, eob, 12'(seq % 4096), len, s};
    endfunction

    function automatic logic [63:0] model_word(input int w, input int n);
        logic [31:0] lo;
        lo = (2 * w + 1 < n) ? smp_q[2 * w + 1] : 32'h0;
        return {smp_q[2 * w], lo};
    endfunction

    function automatic logic [63:0] obs(input int k);
        if (k < obs_q.size()) return obs_q[k];
        return 'x;
    endfunction

    task automatic build_exp(input bit ht, input bit eob, input int n);
        exp_q.delete();
        exp_q.push_back(model_hdr(ht, eob, exp_seq, n, sid));
        if (ht) exp_q.push_back(t_first);
        for (int w = 0; w < (n + 1) / 2; w++) exp_q.push_back(model_word(w, n));
    endtask

    // Offers n samples; sample eob_idx carries i_teob. Fixed data is 0x11*(k+1).
    task automatic drive_pkt(input int n, input int eob_idx, input bit fixed);
        int wt;
        smp_q.delete();
        timed_out = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_tvalid = 1'b1;
            i_tdata  = fixed ? 32'(32'h11 * (k + 1)) : $urandom;
            i_teob   = (k == eob_idx);
            wt = 0;
            while (i_tready !== 1'b1 && wt < 2000) begin
                @(negedge clk);
                wt++;
            end
            if (wt >= 2000) begin
                timed_out = 1;
                break;
            end
            if (k == 0) t_first = vita_time;
            smp_q.push_back(i_tdata);
            @(posedge clk);
            #1;
            vita_time = vita_time + 64'h10;
        end
        i_tvalid = 1'b0;
        i_teob   = 1'b0;
    endtask

    // Receives one packet; mode 0 always ready, 1 toggling, 2 random.
    task automatic collect(input int mode);
        int cyc;
        bit done, stalled;
        logic [63:0] held;
        obs_q.delete();
        last_idx = -1; first_wait = -1; stall_err = 0; rdy_err = 0;
        cyc = 0; done = 0; stalled = 0; held = '0;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            if (mode == 0) o_tready = 1'b1;
            else if (mode == 1) o_tready = (cyc % 2 == 0);
            else o_tready = 1'($urandom_range(0, 1));
            if (o_tvalid === 1'b1) begin
                if (first_wait < 0) first_wait = cyc;
                if (i_tready !== 1'b0) rdy_err++;
                if (stalled && o_tdata !== held) stall_err++;
                if (o_tready) begin
                    obs_q.push_back(o_tdata);
                    stalled = 0;
                    if (o_tlast === 1'b1) begin
                        last_idx = obs_q.size() - 1;
                        done = 1;
                    end
                end else begin
                    stalled = 1;
                    held = o_tdata;
                end
            end
            cyc++;
        end
        if (!done) timed_out = 1;
        @(posedge clk);
        #1;
        rdy_after = i_tready;
        o_tready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (i_tready !== 1'b0) $display("FAIL rst_tready got %b want 0", i_tready); else n_pass++;
        n_checks++; if (o_tvalid !== 1'b0) $display("FAIL rst_tvalid got %b want 0", o_tvalid); else n_pass++;
        n_checks++; if (o_tlast !== 1'b0) $display("FAIL rst_tlast got %b want 0", o_tlast); else n_pass++;
        n_checks++; if (o_tdata !== 64'h0) $display("FAIL rst_tdata got %h want 0", o_tdata); else n_pass++;
        n_checks++; if (seqnum !== 12'h0) $display("FAIL rst_seqnum got %h want 0", seqnum); else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++; if (i_tready !== 1'b0) $display("FAIL rst_tready_pre_clk got %b want 0", i_tready); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (i_tready !== 1'b1) $display("FAIL rst_tready_post_clk got %b want 1", i_tready); else n_pass++;
    endtask

    task automatic test_basic();
        spp = 16'd4; use_time = 1'b0; sid = 32'h0001_0002;
        drive_pkt(4, -1, 1);
        collect(0);
        n_checks++; if (timed_out) $display("FAIL basic_timeout got timeout want packet"); else n_pass++;
        n_checks++; if (obs_q.size() != 3) $display("FAIL basic_words got %0d want 3", obs_q.size()); else n_pass++;
        n_checks++; if (obs(0) !== 64'h0000_0018_0001_0002) $display("FAIL basic_hdr got %h want 0000001800010002", obs(0)); else n_pass++;
        n_checks++; if (obs(1) !== 64'h0000_0011_0000_0022) $display("FAIL basic_w0 got %h want 0000001100000022", obs(1)); else n_pass++;
        n_checks++; if (obs(2) !== 64'h0000_0033_0000_0044) $display("FAIL basic_w1 got %h want 0000003300000044", obs(2)); else n_pass++;
        n_checks++; if (last_idx != 2) $display("FAIL basic_tlast got %0d want 2", last_idx); else n_pass++;
        n_checks++; if (first_wait != 0) $display("FAIL basic_hdr_latency got %0d want 0", first_wait); else n_pass++;
        n_checks++; if (rdy_after !== 1'b1) $display("FAIL basic_rdy_after got %b want 1", rdy_after); else n_pass++;
        n_checks++; if (seqnum !== 12'd1) $display("FAIL basic_seqnum got %0d want 1", seqnum); else n_pass++;
        exp_seq = 1;
    endtask

    task automatic test_time();
        spp = 16'd3; use_time = 1'b1; vita_time = 64'h100;
        drive_pkt(3, -1, 1);
        collect(0);
        n_checks++; if (obs_q.size() != 4) $display("FAIL time_words got %0d want 4", obs_q.size()); else n_pass++;
        n_checks++; if (obs(0) !== 64'h2001_001C_0001_0002) $display("FAIL time_hdr got %h want 2001001C00010002", obs(0)); else n_pass++;
        n_checks++; if (obs(1) !== 64'h100) $display("FAIL time_word got %h want 100", obs(1)); else n_pass++;
        n_checks++; if (obs(2) !== 64'h0000_0011_0000_0022) $display("FAIL time_w0 got %h want 0000001100000022", obs(2)); else n_pass++;
        n_checks++; if (obs(3) !== 64'h0000_0033_0000_0000) $display("FAIL time_w1 got %h want 0000003300000000", obs(3)); else n_pass++;
        n_checks++; if (last_idx != 3) $display("FAIL time_tlast got %0d want 3", last_idx); else n_pass++;
        use_time = 1'b0;
        exp_seq = 2;
    endtask

    task automatic test_eob();
        spp = 16'd8;
        drive_pkt(5, 4, 1);
        collect(0);
        n_checks++; if (obs_q.size() != 4) $display("FAIL eob_words got %0d want 4", obs_q.size()); else n_pass++;
        n_checks++; if (obs(0) !== 64'h1002_001C_0001_0002) $display("FAIL eob_hdr got %h want 1002001C00010002", obs(0)); else n_pass++;
        n_checks++; if (obs(3) !== 64'h0000_0055_0000_0000) $display("FAIL eob_w2 got %h want 0000005500000000", obs(3)); else n_pass++;
        n_checks++; if (last_idx != 3) $display("FAIL eob_tlast got %0d want 3", last_idx); else n_pass++;
        drive_pkt(8, -1, 1);
        collect(2);
        n_checks++; if (obs(0) !== 64'h0003_0028_0001_0002) $display("FAIL eob_next_hdr got %h want 0003002800010002", obs(0)); else n_pass++;
        n_checks++; if (obs(1) !== 64'h0000_0011_0000_0022) $display("FAIL eob_next_w0 got %h want 0000001100000022", obs(1)); else n_pass++;
        n_checks++; if (obs(4) !== 64'h0000_0077_0000_0088) $display("FAIL eob_next_w3 got %h want 0000007700000088", obs(4)); else n_pass++;
        n_checks++; if (last_idx != 4) $display("FAIL eob_next_tlast got %0d want 4", last_idx); else n_pass++;
        n_checks++; if (seqnum !== 12'd4) $display("FAIL eob_seqnum got %0d want 4", seqnum); else n_pass++;
        exp_seq = 4;
    endtask

    task automatic test_backpressure();
        int bad;
        spp = 16'd364; use_time = 1'b0;
        drive_pkt(364, -1, 0);
        collect(1);
        build_exp(1'b0, 1'b0, 364);
        n_checks++; if (obs_q.size() != 183) $display("FAIL bp_words got %0d want 183", obs_q.size()); else n_pass++;
        n_checks++; if (obs(0) !== exp_q[0]) $display("FAIL bp_hdr got %h want %h", obs(0), exp_q[0]); else n_pass++;
        n_checks++; if (obs(0)[47:32] !== 16'd1464) $display("FAIL bp_len got %0d want 1464", obs(0)[47:32]); else n_pass++;
        bad = 0;
        for (int i = 1; i < exp_q.size(); i++) if (obs(i) !== exp_q[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL bp_payload got %0d wrong words want 0", bad); else n_pass++;
        n_checks++; if (stall_err != 0) $display("FAIL bp_stall_stable got %0d changes want 0", stall_err); else n_pass++;
        n_checks++; if (rdy_err != 0) $display("FAIL bp_tready_during_send got %0d highs want 0", rdy_err); else n_pass++;
        n_checks++; if (last_idx != 182) $display("FAIL bp_tlast got %0d want 182", last_idx); else n_pass++;
        exp_seq++;
    endtask

    task automatic test_spp_limits();
        int bad;
        spp = 16'hFFFF; use_time = 1'b1;
        drive_pkt(1024, -1, 0);
        n_checks++; if (i_tready !== 1'b0) $display("FAIL max_close got tready %b want 0", i_tready); else n_pass++;
        collect(2);
        build_exp(1'b1, 1'b0, 1024);
        n_checks++; if (obs_q.size() != 514) $display("FAIL max_words got %0d want 514", obs_q.size()); else n_pass++;
        n_checks++; if (obs(0)[47:32] !== 16'd4112) $display("FAIL max_len got %0d want 4112", obs(0)[47:32]); else n_pass++;
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (obs(i) !== exp_q[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL max_packet got %0d wrong words want 0", bad); else n_pass++;
        exp_seq++;
        spp = 16'd0; use_time = 1'b0;
        for (int p = 0; p < 2; p++) begin
            drive_pkt(1, -1, 0);
            collect(0);
            build_exp(1'b0, 1'b0, 1);
            n_checks++; if (obs_q.size() != 2) $display("FAIL spp0_words got %0d want 2", obs_q.size()); else n_pass++;
            n_checks++; if (obs(0) !== exp_q[0]) $display("FAIL spp0_hdr got %h want %h", obs(0), exp_q[0]); else n_pass++;
            n_checks++; if (obs(1) !== exp_q[1]) $display("FAIL spp0_word got %h want %h", obs(1), exp_q[1]); else n_pass++;
            exp_seq++;
        end
    endtask

    task automatic test_random();
        int sv, e, eob_idx, n, bad;
        bit ut;
        for (int it = 0; it < 30; it++) begin
            sv = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 40));
            ut = 1'($urandom_range(0, 1));
            spp = 16'(sv); use_time = ut; sid = $urandom; vita_time = {$urandom, $urandom};
            e = eff_spp(sv);
            eob_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, e - 1)) : -1;
            n = (eob_idx >= 0) ? eob_idx + 1 : e;
            drive_pkt(n, eob_idx, 0);
            collect(int'($urandom_range(0, 2)));
            build_exp(ut, eob_idx >= 0, n);
            n_checks++; if (timed_out) $display("FAIL rand_timeout it %0d got timeout want packet", it); else n_pass++;
            n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL rand_words it %0d got %0d want %0d", it, obs_q.size(), exp_q.size()); else n_pass++;
            bad = 0;
            for (int i = 0; i < exp_q.size(); i++) if (obs(i) !== exp_q[i]) bad++;
            n_checks++; if (bad != 0) $display("FAIL rand_data it %0d got %0d wrong words want 0 (hdr %h want %h)", it, bad, obs(0), exp_q[0]); else n_pass++;
            n_checks++; if (last_idx != exp_q.size() - 1) $display("FAIL rand_tlast it %0d got %0d want %0d", it, last_idx, exp_q.size() - 1); else n_pass++;
            n_checks++; if (stall_err + rdy_err != 0) $display("FAIL rand_handshake it %0d got %0d errors want 0", it, stall_err + rdy_err); else n_pass++;
            exp_seq = (exp_seq + 1) % 4096;
            n_checks++; if (seqnum !== 12'(exp_seq)) $display("FAIL rand_seqnum it %0d got %0d want %0d", it, seqnum, exp_seq); else n_pass++;
            if (timed_out) break;
        end
        use_time = 1'b0; sid = 32'h0001_0002;
    endtask

    task automatic test_clear();
        spp = 16'd8;
        drive_pkt(3, -1, 0);
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        exp_seq = 0;
        n_checks++; if (seqnum !== 12'd0) $display("FAIL clr_seqnum got %0d want 0", seqnum); else n_pass++;
        spp = 16'd2;
        drive_pkt(2, -1, 0);
        collect(0);
        build_exp(1'b0, 1'b0, 2);
        n_checks++; if (obs_q.size() != 2) $display("FAIL clr_partial_words got %0d want 2", obs_q.size()); else n_pass++;
        n_checks++; if (obs(0) !== exp_q[0]) $display("FAIL clr_partial_hdr got %h want %h", obs(0), exp_q[0]); else n_pass++;
        n_checks++; if (obs(1) !== exp_q[1]) $display("FAIL clr_partial_word got %h want %h", obs(1), exp_q[1]); else n_pass++;
        exp_seq = 1;
        spp = 16'd8;
        drive_pkt(8, -1, 0);
        @(negedge clk); o_tready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (o_tvalid !== 1'b1 || o_tlast !== 1'b0) $display("FAIL clr_mid_payload got valid %b last %b want 1 0", o_tvalid, o_tlast); else n_pass++;
        clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0; o_tready = 1'b0;
        n_checks++; if (o_tvalid !== 1'b0) $display("FAIL clr_tvalid got %b want 0", o_tvalid); else n_pass++;
        n_checks++; if (seqnum !== 12'd0) $display("FAIL clr_seqnum2 got %0d want 0", seqnum); else n_pass++;
        exp_seq = 0;
        spp = 16'd2;
        drive_pkt(2, -1, 0);
        collect(0);
        build_exp(1'b0, 1'b0, 2);
        n_checks++; if (obs(0) !== exp_q[0]) $display("FAIL clr_next_hdr got %h want %h", obs(0), exp_q[0]); else n_pass++;
        exp_seq = 1;
    endtask

    task automatic test_seq_wrap();
        @(negedge clk); clear = 1'b1;
        @(posedge clk); #1; clear = 1'b0;
        exp_seq = 0;
        spp = 16'd2; use_time = 1'b0;
        for (int p = 0; p <= 4096; p++) begin
            drive_pkt(2, -1, 0);
            collect(0);
            n_checks++; if (obs(0)[59:48] !== 12'(exp_seq)) $display("FAIL wrap_hdr_seq pkt %0d got %h want %h", p, obs(0)[59:48], 12'(exp_seq)); else n_pass++;
            exp_seq = (exp_seq + 1) % 4096;
            n_checks++; if (seqnum !== 12'(exp_seq)) $display("FAIL wrap_seqnum pkt %0d got %h want %h", p, seqnum, 12'(exp_seq)); else n_pass++;
            if (timed_out) break;
        end
    endtask

    task automatic test_async_reset();
        spp = 16'd8;
        drive_pkt(8, -1, 0);
        @(negedge clk); o_tready = 1'b1;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (o_tvalid !== 1'b0) $display("FAIL arst_tvalid got %b want 0", o_tvalid); else n_pass++;
        n_checks++; if (o_tdata !== 64'h0) $display("FAIL arst_tdata got %h want 0", o_tdata); else n_pass++;
        n_checks++; if (o_tlast !== 1'b0) $display("FAIL arst_tlast got %b want 0", o_tlast); else n_pass++;
        n_checks++; if (i_tready !== 1'b0) $display("FAIL arst_tready got %b want 0", i_tready); else n_pass++;
        n_checks++; if (seqnum !== 12'd0) $display("FAIL arst_seqnum got %0d want 0", seqnum); else n_pass++;
        o_tready = 1'b0;
        #1 reset_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (i_tready !== 1'b1) $display("FAIL arst_release_tready got %b want 1", i_tready); else n_pass++;
        exp_seq = 0;
        spp = 16'd1;
        drive_pkt(1, -1, 0);
        collect(0);
        build_exp(1'b0, 1'b0, 1);
        n_checks++; if (obs(0) !== exp_q[0]) $display("FAIL arst_next_hdr got %h want %h", obs(0), exp_q[0]); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_time();
        test_eob();
        test_backpressure();
        test_spp_limits();
        test_random();
        test_clear();
        test_seq_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
